// File: rtl/sched_pkg.sv
// Shared types and constants for the channel scheduler.
// The 3-to-8 decoder lives here so every user shares one definition.
package sched_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;
    localparam int CNT_W  = 8;

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    function automatic logic [NUM_CH-1:0] dec3to8(
        input logic [SEL_W-1:0] s
    );
        logic [NUM_CH-1:0] oh;
        oh    = '0;
        oh[s] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/channel_scheduler_rr_pick.sv
// Round-robin pick: first set request at or above ptr, wrapping 7 -> 0.
import sched_pkg::*;

module rr_pick (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  idx,
    output logic              any
);

    logic [2*NUM_CH-1:0] dbl;
    logic [NUM_CH-1:0]   rot;
    logic [SEL_W-1:0]    off;
    logic                found;

    always_comb begin
        dbl   = {req, req} >> ptr;
        rot   = dbl[NUM_CH-1:0];
        off   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rot[i] && !found) begin
                found = 1'b1;
                off   = i[SEL_W-1:0];
            end
        end
        idx = ptr + off;
        any = |req;
    end

endmodule

// File: rtl/channel_scheduler.sv
// Round-robin 8-channel burst scheduler driving a 1-to-8 demux.
// Optional burst extension via lock[] when SCHED_LOCK_EN is defined.
import sched_pkg::*;

module channel_scheduler #(
    parameter int unsigned BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
`ifdef SCHED_LOCK_EN
    input  logic [NUM_CH-1:0] lock,
`endif
    output logic [NUM_CH-1:0] gnt,
    output logic [SEL_W-1:0]  sel,
    output logic              sel_valid
);

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0] gnt_q, gnt_d;

    logic [SEL_W-1:0]  pick_idx;
    logic              pick_any;
    logic [CNT_W-1:0]  cnt_inc;
    logic              burst_ok;
    logic              lock_own;

    rr_pick u_pick (
        .req (req),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

`ifdef SCHED_LOCK_EN
    assign lock_own = lock[sel_q];
`else
    assign lock_own = 1'b0;
`endif

    // Saturating so a locked owner can hold indefinitely.
    assign cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    assign burst_ok = cnt_inc < CNT_W'(BURST_LEN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        unique case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (pick_any) begin
                    state_d = GRANT;
                    sel_d   = pick_idx;
                    cnt_d   = '0;
                    gnt_d   = dec3to8(pick_idx);
                end
            end
            GRANT: begin
                cnt_d = cnt_inc;
                if (!(req[sel_q] && (burst_ok || lock_own))) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = sel_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        gnt       = gnt_q;
        sel       = sel_q;
        sel_valid = |gnt_q;
    end

endmodule

// File: tb/tb_channel_scheduler.sv
// Scoreboard bench for channel_scheduler (BURST_LEN=4).
// Define SCHED_LOCK_EN to also exercise the lock path.
module tb_channel_scheduler;

    localparam int BL = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] lock;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       sel_valid;

    int n_vec;
    int n_err;

    logic [11:0] exp_q[$];

    bit         m_busy;
    logic [2:0] m_own;
    logic [2:0] m_ptr;
    logic [2:0] m_sel;
    int         m_g;

    channel_scheduler #(.BURST_LEN(BL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
`ifdef SCHED_LOCK_EN
        .lock      (lock),
`endif
        .gnt       (gnt),
        .sel       (sel),
        .sel_valid (sel_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: one call per rising edge, from the inputs seen there.
    task automatic model(input logic r, input logic [7:0] q,
                         input logic [7:0] l);
        int ch;
        bit hit;
        if (!r) begin
            m_busy = 0;
            m_ptr  = 0;
            m_sel  = 0;
            m_g    = 0;
        end else if (m_busy) begin
            if (q[m_own] && (l[m_own] || m_g < BL)) begin
                m_g = (m_g >= 255) ? 255 : m_g + 1;
            end else begin
                m_busy = 0;
                m_ptr  = 3'((int'(m_own) + 1) % 8);
            end
        end else begin
            hit = 0;
            for (int i = 0; i < 8; i++) begin
                ch = (int'(m_ptr) + i) % 8;
                if (!hit && q[ch]) begin
                    hit    = 1;
                    m_busy = 1;
                    m_own  = 3'(ch);
                    m_sel  = 3'(ch);
                    m_g    = 1;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic [7:0] q,
                        input logic [7:0] l);
        logic [7:0]  eg;
        logic [11:0] e;
        rst_n = r;
        req   = q;
`ifdef SCHED_LOCK_EN
        lock  = l;
`else
        lock  = 8'h00;
`endif
        model(r, q, lock);
        eg = m_busy ? (8'h01 << m_own) : 8'h00;
        exp_q.push_back({eg, m_sel, m_busy});
        @(posedge clk);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb: scoreboard empty");
        end else begin
            e = exp_q.pop_front();
            check("gnt", gnt, e[11:4]);
            check("sel", {5'b0, sel}, {5'b0, e[3:1]});
            check("vld", {7'b0, sel_valid}, {7'b0, e[0]});
            check("oh", {7'b0, $onehot0(gnt)}, 8'h01);
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        req   = 8'h00;
        lock  = 8'h00;
        m_busy = 0;
        m_own = 0;
        m_ptr = 0;
        m_sel = 0;
        m_g   = 0;
        @(negedge clk);

        // single requester: 4 grant cycles, 1 idle, repeat
        do_reset(2);
        for (int i = 0; i < 12; i++) step(1'b1, 8'h01, 8'h00);

        // ch0 then ch7 then back to ch0
        do_reset(1);
        for (int i = 0; i < 16; i++) step(1'b1, 8'h81, 8'h00);

        // full rotation
        do_reset(1);
        for (int i = 0; i < 46; i++) step(1'b1, 8'hFF, 8'h00);

        // idle stays idle
        for (int i = 0; i < 3; i++) step(1'b1, 8'h00, 8'h00);

        // early drop of ch3; ptr must move to 4
        do_reset(1);
        step(1'b1, 8'h08, 8'h00);
        step(1'b1, 8'h08, 8'h00);
        step(1'b1, 8'h10, 8'h00);
        for (int i = 0; i < 6; i++) step(1'b1, 8'h18, 8'h00);

        // non-owner changes ignored mid-grant
        do_reset(1);
        step(1'b1, 8'h02, 8'h00);
        step(1'b1, 8'h03, 8'h00);
        step(1'b1, 8'hF2, 8'h00);
        for (int i = 0; i < 4; i++) step(1'b1, 8'h0F, 8'h00);

        // reset mid-grant of ch5
        do_reset(1);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h20, 8'h00);
        step(1'b0, 8'hFF, 8'h00);
        for (int i = 0; i < 6; i++) step(1'b1, 8'h24, 8'h00);

`ifdef SCHED_LOCK_EN
        do_reset(1);
        for (int i = 0; i < 11; i++) step(1'b1, 8'h04, 8'h04);
        for (int i = 0; i < 4; i++) step(1'b1, 8'h04, 8'h00);
`endif

        // random traffic with occasional reset
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 40) != 0),
                 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/channel_scheduler.md
CHANNEL_SCHEDULER -- requirements
Module: channel_scheduler

Interface
REQ-001 SHALL have parameter: BURST_LEN, default 4, max consecutive grant cycles per owner (legal 1..255).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port: req  input  8  per-channel request, level-sensitive.
REQ-005 SHALL have port: gnt  output  8  one-hot grant, registered.
REQ-006 SHALL have port: sel  output  3  binary index of granted channel, drives the 1-to-8 demux select.
REQ-007 SHALL have port: sel_valid  output  1  high while a grant is active, gates the demux data input.
REQ-008 SHALL have port (only with SCHED_LOCK_EN): lock  input  8  per-channel burst-extension request.

Function
REQ-009 SHALL implement FSM states IDLE and GRANT.
REQ-010 SHALL, in IDLE with req != 0, select the first set req bit at or above ptr, wrapping 7->0, and enter GRANT next edge.
REQ-011 SHALL assert gnt/sel/sel_valid on the cycle after req is sampled; latency 1 cycle.
REQ-012 SHALL keep gnt one-hot or all-zero; sel equals the encoded gnt; sel_valid = |gnt.
REQ-013 SHALL hold the owner in GRANT while req[owner]=1 and the burst counter < BURST_LEN.
REQ-014 SHALL release when req[owner] drops (gnt clears next edge) or after exactly BURST_LEN grant cycles.
REQ-015 SHALL set ptr = (owner+1) mod 8 on release; 3-bit wrap, 7 -> 0.
REQ-016 SHALL insert exactly one IDLE cycle (gnt=0, sel_valid=0) between consecutive grants; sel holds its last value during it.
REQ-017 SHALL ignore req changes of non-owners during GRANT.
REQ-018 SHALL, with req=0 in IDLE, stay in IDLE with ptr unchanged.
REQ-019 SHALL use an 8-bit burst counter cleared on grant entry and incremented each GRANT cycle.

Reset
REQ-020 SHALL, on rst_n=0 at a clock edge, force state=IDLE, gnt=0, sel=0, sel_valid=0, ptr=0, counter=0.
REQ-021 SHALL abort an active grant on reset mid-burst, with no grant on the cycle after rst_n returns high.
REQ-022 SHALL, while rst_n=0, take no action from req.

Configuration
REQ-023 SHALL compile the lock feature in only when macro SCHED_LOCK_EN is defined.
REQ-024 SHALL, with SCHED_LOCK_EN: while lock[owner]=1 and req[owner]=1, ignore the BURST_LEN limit (counter saturates at 255), and release on req drop or on lock drop when counter >= BURST_LEN.
REQ-025 SHALL, without SCHED_LOCK_EN, omit the lock port; behaviour per REQ-014 only.

Structure
REQ-026 SHALL put in shared package sched_pkg: NUM_CH=8, SEL_W=3, CNT_W=8, state enum {IDLE, GRANT}.
REQ-027 SHALL implement rotate plus priority pick as sub-module rr_pick (inputs req[7:0], ptr[2:0]; outputs idx[2:0], any).
REQ-028 SHALL take the binary-to-one-hot gnt conversion from the existing 3-to-8 decoder.

Verification
REQ-029 SHALL test: reset then req=8'h01 held -> gnt=01 on cycles 2-5 (BURST_LEN=4), 0 on cycle 6, 01 again on cycle 7.
REQ-030 SHALL test: req=8'h81, ptr=0 -> grant ch0 for 4 cycles, 1 idle cycle, then ch7, sel=3'd7; after ch7 ptr=0.
REQ-031 SHALL test: req=8'hFF continuous -> grants rotate 0,1,...,7,0, each 4 cycles plus 1 idle; gnt never multi-hot.
REQ-032 SHALL test: ch3 granted, req[3] drops after 2 cycles -> gnt=0 next edge, ptr=4.
REQ-033 SHALL test: rst_n=0 for 1 cycle mid-grant of ch5 -> all outputs 0 next edge, ptr=0, next grant to lowest set req.
REQ-034 SHALL test (SCHED_LOCK_EN): lock[2]=1, req[2]=1 for 10 cycles -> gnt=04 for 10 cycles; lock drop at cycle 10 -> release next edge.
